dff_pipe: RTL and testbench

//  Parametrised elastic register pipeline: STAGES stages of WIDTH-bit flops with valid/ready

---
 rtl/dff_pkg.sv | 13 +
 rtl/dff_pipe_stage.sv | 31 +++
 rtl/dff_pipe.sv | 90 +++++++++
 tb/tb_dff_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// The occupancy port is present only when DFF_PIPE_OCC_EN is defined.
package dff_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 3;

    // Bits needed to count 0..stages valid entries.
    function automatic int occ_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slice: a valid flag plus a data word, loaded when the ready chain allows.
// Data only captures on a valid source, so bubbles never overwrite held data.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Elastic STAGES-deep register pipeline with valid/ready flow control, bubble collapsing
// and synchronous flush. Define DFF_PIPE_OCC_EN to add the registered occupancy counter.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STAGES    = DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_width(STAGES)-1:0] occupancy
`endif
);

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];

    // A stage may load when it is empty or its successor is moving: stalls stop at bubbles.
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = vld[i-1];
            assign src_data  = dat[i-1];
        end

        assign rdy[i] = !vld[i] | rdy[i+1];

        dff_pipe_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (rdy[i]),
            .src_valid(src_valid),
            .src_data (src_data),
            .valid    (vld[i]),
            .data     (dat[i])
        );
    end

    assign in_ready  = rdy[0] & !flush;
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int OW = occ_width(STAGES);

    logic          acc;
    logic          cons;
    logic [OW-1:0] occ_q;

    assign acc  = in_valid & in_ready;
    assign cons = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (acc && !cons) begin
            occ_q <= occ_q + OW'(1);
        end else if (cons && !acc) begin
            occ_q <= occ_q - OW'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe (WIDTH=8, STAGES=3): hand-derived vector table, stream latency,
// randomised traffic against a stage-level model with a data scoreboard, and async reset.
module tb_dff_pipe;

    localparam int         W  = 8;
    localparam int         S  = 3;
    localparam logic [7:0] RV = 8'hC3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef DFF_PIPE_OCC_EN
    logic [1:0]   occupancy;
`endif

    dff_pipe #(
        .WIDTH    (W),
        .STAGES   (S),
        .RESET_VAL(RV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-stage valid/data following the transfer rule.
    logic         mv [S];
    logic [W-1:0] md [S];
    logic [W-1:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_occ();
        logic [31:0] n = 0;
        for (int i = 0; i < S; i++) n += {31'd0, mv[i]};
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = RV;
        end
        sb.delete();
    endtask

    logic         c_ir, c_ov;
    logic [W-1:0] c_od;
    logic [31:0]  c_occ;

    // One clock cycle: drive, check at negedge, advance model at posedge.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        logic         r [S+1];
        logic         m_ir;
        logic         sv;
        logic [W-1:0] sd;
        logic [W-1:0] exp_d;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        r[S] = ordy;
        for (int i = S - 1; i >= 0; i--) r[i] = !mv[i] | r[i+1];
        m_ir = r[0] & !fl;
        c_ir = in_ready;
        c_ov = out_valid;
        c_od = out_data;
`ifdef DFF_PIPE_OCC_EN
        c_occ = {30'd0, occupancy};
        check("model_occupancy", c_occ, model_occ());
`else
        c_occ = model_occ();
`endif
        check("model_in_ready", {31'd0, in_ready}, {31'd0, m_ir});
        check("model_out_valid", {31'd0, out_valid}, {31'd0, mv[S-1]});
        check("model_out_data", {24'd0, out_data}, {24'd0, md[S-1]});
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_d = sb.pop_front();
                check("sb_data_order", {24'd0, out_data}, {24'd0, exp_d});
            end
        end
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < S; i++) mv[i] = 1'b0;
            sb.delete();
        end else begin
            if (iv && m_ir) sb.push_back(id);
            for (int i = S - 1; i >= 0; i--) begin
                if (r[i]) begin
                    sv = (i == 0) ? iv : mv[i-1];
                    sd = (i == 0) ? id : md[i-1];
                    mv[i] = sv;
                    if (sv) md[i] = sd;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_occ;
    } vec_t;

    vec_t vt [$];

    initial begin
        int first_out;
        int last_out;
        int n_out;
        int stale;

        // Rows: inputs this cycle, outputs expected before the edge (state from previous rows).
        vt.push_back('{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, RV,    0});
        vt.push_back('{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, RV,    1});
        vt.push_back('{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, RV,    2});
        vt.push_back('{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 3});
        vt.push_back('{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 3});
        vt.push_back('{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 3});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 3});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 3});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 1});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA4, 0});
        vt.push_back('{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA4, 0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA4, 1});
        vt.push_back('{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA4, 1});
        vt.push_back('{1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 2});
        vt.push_back('{1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 3});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 3});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 2});
        vt.push_back('{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 2});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 0});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 0});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 0});

        model_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {24'd0, out_data}, {24'd0, RV});
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DFF_PIPE_OCC_EN
        check("reset_occupancy", {30'd0, occupancy}, 32'd0);
`endif
        rst_n = 1'b1;

        // Back-to-back stream with no back-pressure.
        first_out = -1;
        last_out  = -1;
        n_out     = 0;
        for (int k = 0; k < 24; k++) begin
            step(k < 16, 8'(k + 1), 1'b1, 1'b0);
            if (c_ov) begin
                if (first_out < 0) first_out = k;
                last_out = k;
                n_out++;
            end
        end
        check("stream_latency", first_out, 32'd3);
        check("stream_count", n_out, 32'd16);
        check("stream_no_gaps", last_out - first_out + 1, 32'd16);

        // Hand-derived back-pressure, bubble collapse and flush vectors.
        apply_reset();
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].iv, vt[i].id, vt[i].ordy, vt[i].fl);
            check($sformatf("vec%0d_in_ready", i), {31'd0, c_ir}, {31'd0, vt[i].e_ir});
            check($sformatf("vec%0d_out_valid", i), {31'd0, c_ov}, {31'd0, vt[i].e_ov});
            check($sformatf("vec%0d_out_data", i), {24'd0, c_od}, {24'd0, vt[i].e_od});
            check($sformatf("vec%0d_occupancy", i), c_occ, vt[i].e_occ);
        end

        // Random traffic including occasional flush.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset between edges with two words in flight.
        apply_reset();
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data", {24'd0, out_data}, {24'd0, RV});
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DFF_PIPE_OCC_EN
        check("async_rst_occupancy", {30'd0, occupancy}, 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (c_ov) stale++;
        end
        check("async_rst_no_old_data", stale, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
